// File: rtl/grf_pkg.sv
// grf_pkg: shared constants and helpers for the multi-port register file.
// Optional trace output in grf_multi is enabled with GRF_TRACE_EN.
package grf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int PEND_W_DEF = 2;
    localparam int ZERO_REG   = 0;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_INC,
        OP_DEC
    } pend_op_e;

    function automatic int pend_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/grf_pend_ctr.sv
// grf_pend_ctr: saturating pending-write counter for one register.
// Increments stop at the maximum, decrements stop at zero.
module grf_pend_ctr
    import grf_pkg::*;
#(
    parameter int W = PEND_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         nz
);

    localparam logic [W-1:0] MAX = W'(pend_max(W));

    pend_op_e op;

    // inc and dec together cancel out
    always_comb begin
        op = OP_HOLD;
        unique case (1'b1)
            (inc && !dec && cnt != MAX): op = OP_INC;
            (dec && !inc && cnt != '0):  op = OP_DEC;
            default:                     op = OP_HOLD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            unique case (op)
                OP_INC:  cnt <= cnt + 1'b1;
                OP_DEC:  cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign nz = |cnt;

endmodule

// File: rtl/grf_multi.sv
// grf_multi: multi-read-port register file with bypass and pending-write scoreboard.
// Define GRF_TRACE_EN to print a trace line for every write.
module grf_multi
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NUM_RD = 2,
    parameter int PEND_W = PEND_W_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [31:0]              wpc,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [DATA_W-1:0]        wd,
    input  logic                     wb_retire,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rbusy,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_full
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZR = ADDR_W'(ZERO_REG);
    localparam logic [PEND_W-1:0] PMAX = PEND_W'(pend_max(PEND_W));
    localparam logic [PEND_W-1:0] PONE = PEND_W'(1);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0][PEND_W-1:0] cnt;
    logic [DEPTH-1:0] nz;
    logic inc;
    logic dec;

    assign cnt[0] = '0;
    assign nz[0]  = 1'b0;

    assign iss_full = (iss_addr != ZR) && (cnt[iss_addr] == PMAX);
    assign inc = iss_valid && (iss_addr != ZR) && !iss_full;
    assign dec = wb_retire && (wa != ZR) && nz[wa];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && wa != ZR) begin
            regs[wa] <= wd;
        end
    end

    for (genvar r = 1; r < DEPTH; r++) begin : g_ctr
        grf_pend_ctr #(
            .W(PEND_W)
        ) u_ctr (
            .clk  (clk),
            .reset(reset),
            .inc  (inc && iss_addr == ADDR_W'(r)),
            .dec  (dec && wa == ADDR_W'(r)),
            .cnt  (cnt[r]),
            .nz   (nz[r])
        );
    end

    // a last pending write retiring now is covered by the bypass path
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = ra[k*ADDR_W +: ADDR_W];
        assign rd[k*DATA_W +: DATA_W] =
            (a == ZR)            ? '0 :
            (we && wa == a)      ? wd :
                                   regs[a];
        assign rbusy[k] = nz[a] &&
            !(dec && wa == a && cnt[a] == PONE);
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset && wb_retire && wa != ZR) begin
            assert (nz[wa])
            else $warning("grf_multi: retire of reg %0d with no pending write", wa);
        end
    end
`endif

`ifdef GRF_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            $display("@%h: $%d <= %h", wpc, wa, wd);
        end
    end
`else
    logic unused_wpc;
    assign unused_wpc = ^wpc;
`endif

endmodule

// File: tb/tb_grf_multi.sv
// tb_grf_multi: scoreboard bench for grf_multi.
// Expectations are queued with each cycle's stimulus and checked mid-cycle.
module tb_grf_multi;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    localparam int S_RD0 = 0;
    localparam int S_RD1 = 1;
    localparam int S_RB0 = 2;
    localparam int S_RB1 = 3;
    localparam int S_FUL = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             we;
    logic [31:0]      wpc;
    logic [AW-1:0]    wa;
    logic [DW-1:0]    wd;
    logic             wb_retire;
    logic [NR*AW-1:0] ra;
    logic [NR*DW-1:0] rd;
    logic [NR-1:0]    rbusy;
    logic             iss_valid;
    logic [AW-1:0]    iss_addr;
    logic             iss_full;

    grf_multi #(
        .DATA_W(DW),
        .ADDR_W(AW),
        .NUM_RD(NR),
        .PEND_W(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .wpc      (wpc),
        .wa       (wa),
        .wd       (wd),
        .wb_retire(wb_retire),
        .ra       (ra),
        .rd       (rd),
        .rbusy    (rbusy),
        .iss_valid(iss_valid),
        .iss_addr (iss_addr),
        .iss_full (iss_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t q[$];
    int   nchk = 0;
    int   nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input int sel);
        case (sel)
            S_RD0:   return rd[31:0];
            S_RD1:   return rd[63:32];
            S_RB0:   return {31'd0, rbusy[0]};
            S_RB1:   return {31'd0, rbusy[1]};
            default: return {31'd0, iss_full};
        endcase
    endfunction

    task automatic want(input string tag, input int sel,
                        input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        q.push_back(e);
    endtask

    // check queued expectations mid-cycle, then commit at the posedge
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        while (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, pick(e.sel), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we        = 1'b0;
        wb_retire = 1'b0;
        iss_valid = 1'b0;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    initial begin
        reset     = 1'b1;
        wpc       = 32'h0;
        wa        = '0;
        wd        = '0;
        ra        = '0;
        iss_addr  = '0;
        idle();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;

        set_ra(5, 0);
        iss_addr = 3;
        want("rst_rd0", S_RD0, 32'h0);
        want("rst_rd1", S_RD1, 32'h0);
        want("rst_rb0", S_RB0, 0);
        want("rst_rb1", S_RB1, 0);
        want("rst_full", S_FUL, 0);
        cyc();

        we = 1'b1; wa = 5; wd = 32'h1234_5678; wpc = 32'h3000;
        want("wr5_byp", S_RD0, 32'h1234_5678);
        cyc();
        idle();
        want("wr5_arr", S_RD0, 32'h1234_5678);
        cyc();

        we = 1'b1; wa = 0; wd = 32'hFFFF_FFFF;
        want("r0_byp", S_RD1, 32'h0);
        cyc();
        idle();
        want("r0_arr", S_RD1, 32'h0);
        cyc();

        set_ra(7, 7);
        we = 1'b1; wa = 7; wd = 32'hA5A5_A5A5;
        want("byp_rd0", S_RD0, 32'hA5A5_A5A5);
        want("byp_rd1", S_RD1, 32'hA5A5_A5A5);
        cyc();
        idle();
        set_ra(5, 7);
        want("keep5", S_RD0, 32'h1234_5678);
        want("keep7", S_RD1, 32'hA5A5_A5A5);
        cyc();

        set_ra(3, 0);
        iss_valid = 1'b1; iss_addr = 3;
        for (int i = 0; i < 4; i++) begin
            want($sformatf("iss%0d_rb", i), S_RB0, (i == 0) ? 0 : 1);
            want($sformatf("iss%0d_full", i), S_FUL, (i == 3) ? 1 : 0);
            cyc();
        end
        idle();
        want("nowrap_full", S_FUL, 1);
        want("nowrap_rb", S_RB0, 1);
        cyc();

        we = 1'b1; wb_retire = 1'b1; wa = 3; wd = 32'h33;
        want("ret1_rb", S_RB0, 1);
        cyc();
        want("ret2_rb", S_RB0, 1);
        want("ret2_full", S_FUL, 0);
        cyc();
        want("ret3_rb", S_RB0, 0);
        want("ret3_byp", S_RD0, 32'h33);
        cyc();
        idle();
        want("drain_rb", S_RB0, 0);
        want("drain_full", S_FUL, 0);
        cyc();

        set_ra(9, 0);
        iss_valid = 1'b1; iss_addr = 9;
        want("r9_iss_rb", S_RB0, 0);
        cyc();
        we = 1'b1; wb_retire = 1'b1; wa = 9; wd = 32'h99;
        want("r9_both_full", S_FUL, 0);
        want("r9_both_rb", S_RB0, 0);
        cyc();
        idle();
        want("r9_net0_rb", S_RB0, 1);
        cyc();
        we = 1'b1; wb_retire = 1'b1; wa = 9; wd = 32'h9A;
        want("r9_last_rb", S_RB0, 0);
        cyc();
        idle();
        want("r9_empty_rb", S_RB0, 0);
        cyc();
        we = 1'b1; wb_retire = 1'b1; wa = 9; wd = 32'h9B;
        want("uflow_rb", S_RB0, 0);
        want("uflow_byp", S_RD0, 32'h9B);
        cyc();
        idle();
        want("uflow_full", S_FUL, 0);
        want("uflow_rb2", S_RB0, 0);
        want("uflow_wr", S_RD0, 32'h9B);
        cyc();

        set_ra(4, 0);
        iss_valid = 1'b1; iss_addr = 4;
        we = 1'b1; wa = 4; wd = 32'h55;
        cyc();
        we = 1'b0;
        cyc();
        idle();
        want("pre_rst_rd", S_RD0, 32'h55);
        want("pre_rst_rb", S_RB0, 1);
        want("pre_rst_full", S_FUL, 0);
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        want("mid_rst_rd", S_RD0, 32'h0);
        want("mid_rst_rb", S_RB0, 0);
        want("mid_rst_full", S_FUL, 0);
        cyc();

        if (q.size() != 0) begin
            nerr++;
            $display("FAIL leftover: got %0d queued, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
